// File: rtl/ev21g1_fetch_queue.sv
// ev21g1 fetch front-end: issues program-memory reads and buffers {pc, instr} for decode.
// Optional delivered-instruction counter enabled by defining EV21G1_FETCH_STATS_EN.
module ev21g1_fetch_queue #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          INSTR_WIDTH = 32,
  parameter int          DEPTH       = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_rd,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic [15:0]            fetch_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = PTR_W + 2;
  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                   inflight_q, inflight_d;
  logic                   kill_q, kill_d;
  logic [ADDR_WIDTH-1:0]  ret_addr_q, ret_addr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic [INSTR_WIDTH-1:0] fifo_instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc_q    [DEPTH];

  logic                   inflight_live;
  logic                   push;
  logic                   pop;
  logic                   issue;
  logic [OUT_W-1:0]       outstanding;

  assign inflight_live = inflight_q & ~kill_q;
  assign push          = inflight_live & ~redirect_valid;
  assign pop           = out_valid & out_ready & ~redirect_valid;

  // Every read already committed (buffered, returning now, or issued last cycle) holds a slot.
  assign outstanding = OUT_W'(count_q) + OUT_W'(inflight_live) + OUT_W'(mem_rd_q);
  assign issue       = ~redirect_valid & (outstanding < OUT_W'(DEPTH));

  always_comb begin
    pc_d       = pc_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    inflight_d = mem_rd_q;
    kill_d     = redirect_valid;
    ret_addr_d = mem_addr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      // Restart fetch at the target immediately so its first word is visible three cycles later.
      pc_d       = redirect_pc + ADDR_WIDTH'(1);
      mem_rd_d   = 1'b1;
      mem_addr_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        pc_d       = pc_q + ADDR_WIDTH'(1);
        mem_rd_d   = 1'b1;
        mem_addr_d = pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RST_PC;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= RST_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      ret_addr_q <= RST_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      ret_addr_q <= ret_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_instr_q[wr_ptr_q] <= mem_data;
      fifo_pc_q[wr_ptr_q]    <= ret_addr_q;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = (count_q != '0);
  // Storage is not reset, so the head is masked to zero while empty.
  assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q] : '0;

`ifdef EV21G1_FETCH_STATS_EN
  logic [15:0] fetch_count_q;

  always_ff @(posedge clk) begin
    if (reset) fetch_count_q <= '0;
    else if (pop) fetch_count_q <= fetch_count_q + 16'd1;
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_ev21g1_fetch_queue.sv
// Scoreboard bench for ev21g1_fetch_queue: expected delivery stream is derived from
// reset/redirect stimulus and checked by an independent monitor on each handshake.
module tb_ev21g1_fetch_queue;
  localparam int AW       = 10;
  localparam int IW       = 32;
  localparam int DEPTH    = 4;
  localparam int RESET_PC = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [IW-1:0] mem_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [15:0]   fetch_count;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_next;
  logic [15:0]   exp_fetch;

  ev21g1_fetch_queue #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'hA000_0000 + {{(IW-AW){1'b0}}, a};
  endfunction

  // Synchronous program memory: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) mem_data <= mem_rd ? mem_word(mem_addr) : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_fc();
`ifdef EV21G1_FETCH_STATS_EN
    return exp_fetch;
`else
    return 16'd0;
`endif
  endfunction

  task automatic top_up();
    while (exp_q.size() < 32) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 1'b1;
    end
  endtask

  task automatic restart(input logic [AW-1:0] p);
    exp_q.delete();
    exp_next = p;
    top_up();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    top_up();
  endtask

  task automatic do_reset(input logic rdy);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = rdy;
    restart(AW'(RESET_PC));
    exp_fetch = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Monitor: every accepted handshake must deliver the next expected pc and its word.
  always @(negedge clk) begin
    if (reset === 1'b0 && redirect_valid === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual_pc=%h at %0t", out_pc, $time);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        chk("deliver_pc", 32'(out_pc), 32'(e));
        chk("deliver_instr", out_instr, mem_word(e));
        exp_fetch = exp_fetch + 16'd1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    exp_next = '0; exp_fetch = '0;

    // Reset state and start-up latency, streaming
    do_reset(1'b1);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_addr", 32'(mem_addr), RESET_PC);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_pc", 32'(out_pc), 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_fetch_count", 32'(fetch_count), 0);
    tick();
    chk("c1_mem_rd", 32'(mem_rd), 1);
    chk("c1_mem_addr", 32'(mem_addr), RESET_PC);
    chk("c1_out_valid", 32'(out_valid), 0);
    tick();
    chk("c2_out_valid", 32'(out_valid), 0);
    tick();
    chk("c3_out_valid", 32'(out_valid), 1);
    chk("c3_out_pc", 32'(out_pc), RESET_PC);
    chk("c3_out_instr", out_instr, 32'hA000_0000);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b1) n++;
    end
    chk("stream_bubbles", n, 0);
    chk("stream_fetch_count", 32'(fetch_count), 32'(exp_fc()));

    // Back-pressure from reset: exactly DEPTH reads
    do_reset(1'b0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_rd === 1'b1) n++;
    end
    chk("full_reads", n, DEPTH);
    chk("full_mem_rd", 32'(mem_rd), 0);
    chk("full_out_valid", 32'(out_valid), 1);
    chk("full_out_pc", 32'(out_pc), 0);
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid !== 1'b1) n++;
    end
    chk("drain_gaps", n, 0);

    // Redirect with 3 buffered entries and a read returning
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 10'h100;
    restart(10'h100);
    tick();
    redirect_valid = 1'b0;
    chk("r1_out_valid", 32'(out_valid), 0);
    chk("r1_mem_rd", 32'(mem_rd), 1);
    chk("r1_mem_addr", 32'(mem_addr), 32'h100);
    tick();
    chk("r2_out_valid", 32'(out_valid), 0);
    tick();
    chk("r3_out_valid", 32'(out_valid), 1);
    chk("r3_out_pc", 32'(out_pc), 32'h100);
    chk("r3_out_instr", out_instr, 32'hA000_0100);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // Redirect coinciding with a handshake, target near the top of the address space
    chk("pre_redir_valid", 32'(out_valid), 1);
    redirect_valid = 1'b1; redirect_pc = 10'h3FE;
    restart(10'h3FE);
    tick();
    redirect_valid = 1'b0;
    chk("redir_hs_fetch_count", 32'(fetch_count), 32'(exp_fc()));
    chk("redir_hs_out_valid", 32'(out_valid), 0);
    tick();
    tick();
    chk("wrap_pc0", 32'(out_pc), 32'h3FE);
    tick();
    chk("wrap_pc1", 32'(out_pc), 32'h3FF);
    tick();
    chk("wrap_pc2", 32'(out_pc), 32'h000);
    tick();
    chk("wrap_pc3", 32'(out_pc), 32'h001);
    chk("wrap_fetch_count", 32'(fetch_count), 32'(exp_fc()));

    // Reset mid-stream with FIFO full
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("midrst_full_valid", 32'(out_valid), 1);
    reset = 1'b1;
    restart(AW'(RESET_PC));
    exp_fetch = '0;
    tick();
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_mem_rd", 32'(mem_rd), 0);
    chk("midrst_fetch_count", 32'(fetch_count), 0);
    reset = 1'b0;
    tick();
    chk("midrst_restart_rd", 32'(mem_rd), 1);
    chk("midrst_restart_addr", 32'(mem_addr), RESET_PC);
    out_ready = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        do_reset(out_ready);
        chk("rand_rst_fetch_count", 32'(fetch_count), 0);
      end else if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? AW'(10'h3FC + $urandom_range(0, 3)) : AW'($urandom);
        restart(redirect_pc);
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
      if (i % 64 == 63) chk("rand_fetch_count", 32'(fetch_count), 32'(exp_fc()));
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("final_fetch_count", 32'(fetch_count), 32'(exp_fc()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
